// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle.
// Optional DIV_EARLY_EXIT_EN skips the iterations when |dividend| < |divisor|.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

`ifdef DIV_EARLY_EXIT_EN
  typedef enum logic [2:0] {ST_FREE, ST_BYZERO, ST_ON, ST_END, ST_EARLY} state_t;
`else
  typedef enum logic [2:0] {ST_FREE, ST_BYZERO, ST_ON, ST_END} state_t;
`endif

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [DATA_W-1:0]   dvd, dvd_next;
  logic [DATA_W-1:0]   dvs, dvs_next;
  logic [DATA_W-1:0]   rem, rem_next;
  logic [DATA_W-1:0]   quo, quo_next;
  logic                sign1, sign1_next;
  logic                sign2, sign2_next;
  logic [2*DATA_W-1:0] result_next;
  logic                ready_next;

  logic                op1_neg, op2_neg;
  logic [DATA_W-1:0]   op1_abs, op2_abs;
  logic [DATA_W:0]     shifted, diff;
  logic                ge;
  logic [DATA_W-1:0]   step_rem, step_quo;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ~v + DATA_W'(1);
  endfunction

  assign stallreq_o = start_i & ~annul_i & ~ready_o;

  // Operand magnitudes and one restoring step; the subtractor is one bit wider than the data
  always_comb begin
    op1_neg  = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg  = signed_div_i & opdata2_i[DATA_W-1];
    op1_abs  = op1_neg ? negate(opdata1_i) : opdata1_i;
    op2_abs  = op2_neg ? negate(opdata2_i) : opdata2_i;
    shifted  = {rem, dvd[DATA_W-1]};
    diff     = shifted - {1'b0, dvs};
    ge       = (shifted >= {1'b0, dvs});
    step_rem = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    step_quo = {quo[DATA_W-2:0], ge};
  end

  // Next-state and datapath control
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    dvd_next    = dvd;
    dvs_next    = dvs;
    rem_next    = rem;
    quo_next    = quo;
    sign1_next  = sign1;
    sign2_next  = sign2;
    result_next = result_o;
    ready_next  = 1'b0;
    case (state)
      ST_FREE: begin
        result_next = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_next = ST_BYZERO;
          end
`ifdef DIV_EARLY_EXIT_EN
          else if (op1_abs < op2_abs) begin
            rem_next   = opdata1_i;
            state_next = ST_EARLY;
          end
`endif
          else begin
            dvd_next   = op1_abs;
            dvs_next   = op2_abs;
            rem_next   = '0;
            quo_next   = '0;
            sign1_next = op1_neg;
            sign2_next = op2_neg;
            cnt_next   = '0;
            state_next = ST_ON;
          end
        end else begin
          state_next = ST_FREE;
        end
      end
      ST_BYZERO: begin
        result_next = '0;
        state_next  = ST_END;
      end
`ifdef DIV_EARLY_EXIT_EN
      ST_EARLY: begin
        result_next = {rem, {DATA_W{1'b0}}};
        state_next  = ST_END;
      end
`endif
      ST_ON: begin
        if (annul_i) begin
          state_next = ST_FREE;
        end else begin
          rem_next = step_rem;
          quo_next = step_quo;
          dvd_next = {dvd[DATA_W-2:0], 1'b0};
          cnt_next = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) begin
            // Remainder follows the dividend's sign, quotient the XOR of both signs
            result_next = {(sign1 ? negate(step_rem) : step_rem),
                           ((sign1 ^ sign2) ? negate(step_quo) : step_quo)};
            state_next  = ST_END;
          end else begin
            state_next = ST_ON;
          end
        end
      end
      ST_END: begin
        if (!start_i || annul_i) begin
          result_next = '0;
          state_next  = ST_FREE;
        end else begin
          ready_next = 1'b1;
        end
      end
      default: begin
        result_next = '0;
        state_next  = ST_FREE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FREE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      dvd      <= dvd_next;
      dvs      <= dvs_next;
      rem      <= rem_next;
      quo      <= quo_next;
      sign1    <= sign1_next;
      sign2    <= sign2_next;
      result_o <= result_next;
      ready_o  <= ready_next;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vector table, corner sequences and
// random operations compared against an arithmetic reference model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int total = 0;
  int bad = 0;

  div_seq #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div),
    .opdata1_i(op1), .opdata2_i(op2), .start_i(start), .annul_i(annul),
    .result_o(result), .ready_o(ready), .stallreq_o(stallreq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int model_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (s && a[31]) ? (32'd0 - a) : a;
    mb = (s && b[31]) ? (32'd0 - b) : b;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_EXIT_EN
    if (ma < mb) return 2;
`else
    if (ma < mb) return 33;
`endif
    return 33;
  endfunction

  // Issue a request and hold start until ready; operands are scrambled after acceptance.
  task automatic run_op(input string name, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    int stall_bad;
    @(negedge clk);
    signed_div = s; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    @(posedge clk); #1;
    op1 = $urandom; op2 = $urandom; signed_div = ~s;
    lat = 0; stall_bad = 0;
    while (!ready && lat < 100) begin
      if (!stallreq) stall_bad++;
      @(posedge clk); #1;
      lat++;
    end
    check({name, " result"}, result, exp);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " stall before ready"}, 64'(stall_bad), 64'd0);
    check({name, " stall after ready"}, {63'd0, stallreq}, 64'd0);
  endtask

  task automatic release_start(input string name);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({name, " ready cleared"}, {63'd0, ready}, 64'd0);
    check({name, " result cleared"}, result, 64'd0);
  endtask

  vec_t vecs[7];
  logic [63:0] held;
  int ready_seen;

  initial begin
    vecs[0] = '{1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
    vecs[2] = '{1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33};
    vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33};
    vecs[4] = '{1'b0, 32'd5, 32'd0, 64'd0, 2};
`ifdef DIV_EARLY_EXIT_EN
    vecs[5] = '{1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 2};
    vecs[6] = '{1'b1, 32'hFFFFFFFB, 32'd9, {32'hFFFFFFFB, 32'd0}, 2};
`else
    vecs[5] = '{1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 33};
    vecs[6] = '{1'b1, 32'hFFFFFFFB, 32'd9, {32'hFFFFFFFB, 32'd0}, 33};
`endif

    #12;
    check("reset ready", {63'd0, ready}, 64'd0);
    check("reset result", result, 64'd0);
    check("reset stall", {63'd0, stallreq}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      release_start($sformatf("vec%0d", i));
    end

    // Start held in END: outputs stay put, then clear when start drops
    run_op("hold", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33);
    held = result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold ready", {63'd0, ready}, 64'd1);
      check("hold result", result, held);
    end
    release_start("hold");

    // Annul in the middle of the iterations
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd77; op2 = 32'd3; start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    #1 check("annul stall", {63'd0, stallreq}, 64'd0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    ready_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready) ready_seen++;
    end
    check("annul no ready", 64'(ready_seen), 64'd0);
    run_op("after annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
    release_start("after annul");

    // start and annul together in FREE: request ignored
    @(negedge clk);
    op1 = 32'd8; op2 = 32'd0; start = 1'b1; annul = 1'b1;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    ready_seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ready) ready_seen++;
    end
    check("start+annul ignored", 64'(ready_seen), 64'd0);

    // Reset asserted mid-iteration and again while holding a result
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd12345; op2 = 32'd7; start = 1'b1;
    repeat (16) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst mid-on ready", {63'd0, ready}, 64'd0);
    check("rst mid-on result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op("pre-rst", 1'b0, 32'd50, 32'd6, {32'd2, 32'd8}, 33);
    #2 rst = 1'b1;
    #1 check("rst in end ready", {63'd0, ready}, 64'd0);
    check("rst in end result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op("post-rst 5/9", 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, vecs[5].lat);
    release_start("post-rst");

    // Randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      logic s;
      logic [31:0] a, b;
      s = 1'($urandom_range(1, 0));
      a = $urandom;
      case ($urandom_range(3, 0))
        0: b = 32'd0;
        1: b = 32'($urandom_range(20, 1));
        2: b = $urandom >> $urandom_range(31, 0);
        default: b = $urandom;
      endcase
      if (i % 10 == 3) a = 32'($urandom_range(15, 0));
      run_op($sformatf("rand%0d", i), s, a, b, model(s, a, b), model_lat(s, a, b));
      release_start($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
